// File: rtl/dmem_bus_bridge_pkg.sv
// Shared types and constants for the data-memory bus bridge.
package dmem_bus_bridge_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} dmem_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Width that can hold the values 0 through cycles.
  function automatic int unsigned ctr_width(int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// Core-side request and external memory bus signals of the data-memory bridge.
interface dmem_bus_bridge_if;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_write;
  logic        core_read;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;
  logic        bus_err;

  modport master (
    input  core_addr, core_wdata, core_write, core_read, bus_req_ready, bus_rsp_valid,
           bus_rsp_data,
    output core_rdata, core_stall, bus_req_valid, bus_addr, bus_wdata, bus_we, bus_err
  );

  modport slave (
    output core_addr, core_wdata, core_write, core_read, bus_req_ready, bus_rsp_valid,
           bus_rsp_data,
    input  core_rdata, core_stall, bus_req_valid, bus_addr, bus_wdata, bus_we, bus_err
  );
endinterface

// File: rtl/dmem_bus_bridge_timeout_ctr.sv
// Bus timeout counter: tc_o flags the cycle in which the count would reach TIMEOUT_CYCLES.
module dmem_timeout_ctr
  import dmem_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int unsigned CntW = ctr_width(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign tc_o = en_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/dmem_bus_bridge.sv
// Data-memory bus bridge: core load/store to valid/ready bus with stall and timeout.
// Optional one-entry last-read buffer enabled by defining DMEM_LAST_READ_BUF_EN.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  dmem_bus_bridge_if.master dmem
);
  dmem_state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        we_q, we_d, err_q, err_d;
  logic        req, stall, ctr_clr, ctr_en, ctr_tc;
  logic        rsp_done, timeout_evt;
  logic        buf_hit;
  logic [31:0] buf_data;
  logic        unused_addr;

  assign req         = dmem.core_read | dmem.core_write;
  assign unused_addr = ^dmem.core_addr[1:0];
  assign ctr_en      = (state_q == StReq) || (state_q == StWait);

  dmem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk  (clk),
    .reset(reset),
    .clr_i(ctr_clr),
    .en_i (ctr_en),
    .tc_o (ctr_tc)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    stall       = 1'b0;
    ctr_clr     = 1'b0;
    rsp_done    = 1'b0;
    timeout_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = req;
        if (buf_hit) begin
          rdata_d = buf_data;
          state_d = StDone;
        end else if (req) begin
          addr_d  = {dmem.core_addr[31:2], 2'b00};
          wdata_d = dmem.core_wdata;
          we_d    = dmem.core_write;
          ctr_clr = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        stall = 1'b1;
        if (ctr_tc) begin
          timeout_evt = 1'b1;
        end else if (dmem.bus_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        stall = 1'b1;
        // A response arriving in the timeout cycle still completes normally.
        if (dmem.bus_rsp_valid) begin
          rsp_done = 1'b1;
          if (!we_q) begin
            rdata_d = dmem.bus_rsp_data;
          end
          state_d = StDone;
        end else if (ctr_tc) begin
          timeout_evt = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (timeout_evt) begin
      err_d   = 1'b1;
      state_d = StDone;
      if (!we_q) begin
        rdata_d = ERR_DATA;
      end
    end
  end

`ifdef DMEM_LAST_READ_BUF_EN
  logic        buf_valid_q;
  logic [29:0] buf_tag_q;
  logic [31:0] buf_data_q;

  assign buf_hit  = (state_q == StIdle) && dmem.core_read && !dmem.core_write &&
                    buf_valid_q && (buf_tag_q == dmem.core_addr[31:2]);
  assign buf_data = buf_data_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else if (timeout_evt) begin
      buf_valid_q <= 1'b0;
    end else if (rsp_done) begin
      if (!we_q) begin
        buf_valid_q <= 1'b1;
        buf_tag_q   <= addr_q[31:2];
        buf_data_q  <= dmem.bus_rsp_data;
      end else if (buf_valid_q && (buf_tag_q == addr_q[31:2])) begin
        buf_data_q  <= wdata_q;
      end
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign dmem.core_rdata    = rdata_q;
  assign dmem.core_stall    = stall;
  assign dmem.bus_req_valid = (state_q == StReq);
  assign dmem.bus_addr      = addr_q;
  assign dmem.bus_wdata     = wdata_q;
  assign dmem.bus_we        = we_q;
  assign dmem.bus_err       = err_q;
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge; buffer expectations follow DMEM_LAST_READ_BUF_EN.
module tb_dmem_bus_bridge;
  import dmem_bus_bridge_pkg::*;

`ifdef DMEM_LAST_READ_BUF_EN
  localparam bit BufEn = 1'b1;
`else
  localparam bit BufEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_bus_bridge_if bif ();

  dmem_bus_bridge #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .dmem (bif)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } bus_exp_t;

  typedef struct {
    int          stalls;
    logic [31:0] rdata;
    logic        err;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int checks = 0;
  int failures = 0;

  int          rdy_cnt = 0;
  int          rsp_cnt = 0;
  int          sl_rsp_dly = 1;
  bit          rsp_pending = 1'b0;
  bit          sl_respond = 1'b1;
  logic [31:0] sl_data = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Slave: ready after rdy_cnt cycles of valid, response sl_rsp_dly cycles after acceptance.
  initial begin
    bif.bus_req_ready = 1'b0;
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bif.bus_req_ready = 1'b0;
      bif.bus_rsp_valid = 1'b0;
      if (rsp_pending) begin
        if (rsp_cnt == 0) begin
          bif.bus_rsp_valid = 1'b1;
          bif.bus_rsp_data  = sl_data;
          rsp_pending       = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end else if (bif.bus_req_valid) begin
        if (rdy_cnt == 0) begin
          bif.bus_req_ready = 1'b1;
          if (sl_respond) begin
            rsp_pending = 1'b1;
            rsp_cnt     = sl_rsp_dly - 1;
          end
        end else begin
          rdy_cnt--;
        end
      end
    end
  end

  // Monitor: bus requests and transaction completions against the scoreboard queues.
  initial begin
    bit        in_req;
    int        stall_cnt;
    bus_exp_t  cur;
    done_exp_t de;
    in_req    = 1'b0;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (bif.bus_req_valid) begin
        if (!in_req) begin
          if (bus_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_bus_req: addr %h seen, no request expected", bif.bus_addr);
          end else begin
            cur = bus_q.pop_front();
          end
          in_req = 1'b1;
        end
        chk("bus_addr", bif.bus_addr, cur.addr);
        chk("bus_wdata", bif.bus_wdata, cur.wdata);
        chk("bus_we", 32'(bif.bus_we), 32'(cur.we));
      end else begin
        in_req = 1'b0;
      end
      if (bif.core_stall) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: stall of %0d cycles, no completion expected", stall_cnt);
        end else begin
          de = done_q.pop_front();
          chk("stall_cycles", 32'(stall_cnt), 32'(de.stalls));
          chk("core_rdata", bif.core_rdata, de.rdata);
          chk("bus_err", 32'(bif.bus_err), 32'(de.err));
        end
        stall_cnt = 0;
      end
    end
  end

  // Issue one core request at posedge+1 and hold it until the DONE cycle has passed.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input int rdy, input int rsp_dly,
                     input bit respond, input logic [31:0] rsp_data, input bit to_bus,
                     input logic [31:0] exp_addr, input int exp_stalls,
                     input logic [31:0] exp_rdata, input bit exp_err);
    bus_exp_t  b;
    done_exp_t d;
    int        n;
    rdy_cnt    = rdy;
    sl_rsp_dly = rsp_dly;
    sl_respond = respond;
    sl_data    = rsp_data;
    if (to_bus) begin
      b.addr  = exp_addr;
      b.wdata = wdata;
      b.we    = wr;
      bus_q.push_back(b);
    end
    d.stalls = exp_stalls;
    d.rdata  = exp_rdata;
    d.err    = exp_err;
    done_q.push_back(d);
    bif.core_read  = rd;
    bif.core_write = wr;
    bif.core_addr  = addr;
    bif.core_wdata = wdata;
    n = 0;
    @(negedge clk);
    while (bif.core_stall && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bif.core_stall) begin
      checks++;
      failures++;
      $display("FAIL txn_stuck: addr %h still stalled after %0d cycles, required release", addr, n);
    end
    @(posedge clk);
    #1;
    bif.core_read  = 1'b0;
    bif.core_write = 1'b0;
  endtask

  initial begin
    bus_exp_t  b;
    done_exp_t d;
    bif.core_read  = 1'b0;
    bif.core_write = 1'b0;
    bif.core_addr  = '0;
    bif.core_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", bif.core_rdata, 32'h0);
    chk("rst_req_valid", 32'(bif.bus_req_valid), 32'h0);
    chk("rst_bus_addr", bif.bus_addr, 32'h0);
    chk("rst_bus_wdata", bif.bus_wdata, 32'h0);
    chk("rst_bus_we", 32'(bif.bus_we), 32'h0);
    chk("rst_bus_err", 32'(bif.bus_err), 32'h0);
    chk("rst_stall", 32'(bif.core_stall), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(StIdle));
    reset = 1'b1;
    @(posedge clk);
    #1;

    txn(1, 0, 32'h104, 32'h0, 0, 1, 1, 32'h1234_5678, 1, 32'h104, 3, 32'h1234_5678, 0);
    txn(0, 1, 32'h203, 32'hCAFE_F00D, 0, 1, 1, 32'h0, 1, 32'h200, 3, 32'h1234_5678, 0);
    // Read and write together behave as a write.
    txn(1, 1, 32'h10C, 32'h55AA_55AA, 0, 1, 1, 32'hFFFF_0000, 1, 32'h10C, 3, 32'h1234_5678, 0);
    // Ready held low for 5 cycles: 1 idle + 6 req + 1 wait stall cycles.
    txn(1, 0, 32'h300, 32'h0, 5, 1, 1, 32'hA5A5_0001, 1, 32'h300, 8, 32'hA5A5_0001, 0);
    txn(1, 0, 32'h40, 32'h0, 0, 2, 1, 32'h1111_2222, 1, 32'h40, 4, 32'h1111_2222, 0);
    txn(1, 0, 32'h40, 32'h0, 0, 1, 1, 32'h1111_2222, !BufEn, 32'h40, BufEn ? 1 : 3,
        32'h1111_2222, 0);
    txn(0, 1, 32'h40, 32'h7, 0, 1, 1, 32'h0, 1, 32'h40, 3, 32'h1111_2222, 0);
    txn(1, 0, 32'h40, 32'h0, 0, 1, 1, 32'h7, !BufEn, 32'h40, BufEn ? 1 : 3, 32'h7, 0);
    // Slave accepts but never answers: 1 req + 7 wait cycles then forced completion.
    txn(1, 0, 32'h600, 32'h0, 0, 1, 0, 32'h0, 1, 32'h600, 9, 32'hDEAD_BEEF, 1);
    // Timeout invalidated the buffer; the error flag stays set.
    txn(1, 0, 32'h40, 32'h0, 0, 1, 1, 32'h3333_4444, 1, 32'h40, 3, 32'h3333_4444, 1);

    // Reset during WAIT; the slave's late response must be ignored.
    rdy_cnt    = 0;
    sl_rsp_dly = 3;
    sl_respond = 1'b1;
    sl_data    = 32'h9999_9999;
    b.addr  = 32'h700;
    b.wdata = 32'h0;
    b.we    = 1'b0;
    bus_q.push_back(b);
    d.stalls = 3;
    d.rdata  = 32'h0;
    d.err    = 1'b0;
    done_q.push_back(d);
    bif.core_read = 1'b1;
    bif.core_addr = 32'h700;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("state_before_reset", 32'(dut.state_q), 32'(StWait));
    reset         = 1'b0;
    bif.core_read = 1'b0;
    @(posedge clk);
    #1;
    chk("valid_after_reset", 32'(bif.bus_req_valid), 32'h0);
    chk("state_after_reset", 32'(dut.state_q), 32'(StIdle));
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("late_rsp_rdata", bif.core_rdata, 32'h0);
    chk("late_rsp_stall", 32'(bif.core_stall), 32'h0);
    chk("late_rsp_state", 32'(dut.state_q), 32'(StIdle));

    // Reset also invalidated the buffer.
    txn(1, 0, 32'h40, 32'h0, 0, 1, 1, 32'h5555_6666, 1, 32'h40, 3, 32'h5555_6666, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
    chk("done_q_drained", 32'(done_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

Data-memory bus bridge directly downstream of the pipeline's memory stage. Accepts the core's single-cycle data requests (address, write data, read/write strobes), runs them as valid/ready transactions on an external memory bus with arbitrary latency, and returns read data plus a stall signal. The stall feeds the pipeline's external stall input. A bus timeout guards against a hung slave.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in REQ+WAIT before forced completion; must be ≥ 2.
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `core_addr`  in  32  byte address from the memory stage.
- `core_wdata`  in  32  store data.
- `core_write`  in  1  store request.
- `core_read`  in  1  load request.
- `core_rdata`  out  32  load result; registered.
- `core_stall`  out  1  hold the pipeline; combinational from state and inputs.
- `bus_req_valid`  out  1  request valid.
- `bus_req_ready`  in  1  slave accepts the request.
- `bus_addr`  out  32  word-aligned address: `{core_addr[31:2], 2'b00}`.
- `bus_wdata`  out  32  store data.
- `bus_we`  out  1  1 = write, 0 = read.
- `bus_rsp_valid`  in  1  read data valid / write acknowledge.
- `bus_rsp_data`  in  32  read data.
- `bus_err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- The state machine has four states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - On `core_read | core_write`: latch address, data and `we`, then go to REQ.
  - `core_stall` = `core_read | core_write`.
- **REQ**
  - `bus_req_valid` = 1; bus outputs come from the latched registers.
  - On `bus_req_ready`: go to WAIT.
- **WAIT**
  - `bus_req_valid` = 0.
  - On `bus_rsp_valid`: capture `bus_rsp_data` into `core_rdata` (reads only; writes leave it unchanged), then go to DONE.
- **DONE**
  - `core_stall` = 0 for exactly one cycle; the pipeline advances. Then go to IDLE.
- In REQ and WAIT, `core_stall` = 1 unconditionally.
- Read and write both high: treated as a write.
- Core contract: the request stays stable while `core_stall` = 1. The bridge uses latched copies, so mid-transaction input changes are ignored.
- `bus_rsp_valid` is ignored outside WAIT. A response in the same cycle as acceptance (REQ) is not legal.
- **Timeout**
  - The counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES`: go to DONE, set `core_rdata` = `ERR_DATA` (reads), set `bus_err` = 1, and drop `bus_req_valid`.
  - If the timeout and `bus_rsp_valid` occur in the same cycle, the response wins.
- Reset mid-transaction: next state is IDLE and `bus_req_valid` drops at that edge. No abort is signalled to the slave.

## Timing
- Reset values: state IDLE, `core_rdata` 0, `bus_req_valid` 0, `bus_addr` 0, `bus_wdata` 0, `bus_we` 0, `bus_err` 0, counter 0. `core_stall` is 0 while the core is idle.
- Minimum bus transaction latency (request cycle to DONE): 3 cycles when ready is immediate and the response arrives 1 cycle later. The pipeline is stalled for 3 cycles.
- `core_rdata` is valid from the DONE cycle until the next read completes.
- Back-to-back requests: the next request is taken in IDLE the cycle after DONE. There is no bus turnaround gap beyond that.

## Configuration
- `DMEM_LAST_READ_BUF_EN`: one-entry last-read buffer.
  - The buffer holds the word address and data of the last completed read.
  - A read in IDLE that hits the buffer (tag valid, same word address) goes straight to DONE with buffered data. There is no bus activity and only 1 stall cycle.
  - Any write to the same word updates the buffer data; a timeout invalidates the buffer; reset invalidates it.
- Without the macro: no buffer. Every read goes to the bus.

## Structure
- Package `dmem_bus_bridge_pkg`:
  - state enum `dmem_state_t` (IDLE/REQ/WAIT/DONE)
  - default `ERR_DATA` constant
  - timeout-counter width function `$clog2(TIMEOUT_CYCLES+1)`
- One sub-module, `dmem_timeout_ctr`: clear, enable and terminal-count output.

## Test plan
- Read at 0x104, ready immediate, response 0x1234_5678 after 1 cycle → `bus_addr` = 0x104, `bus_we` = 0, stall high for 3 cycles, `core_rdata` = 0x1234_5678.
- Write 0xCAFE_F00D at 0x203 → `bus_addr` = 0x200, `bus_we` = 1, `core_rdata` unchanged, stall released on ack.
- Slave holds `bus_req_ready` low for 5 cycles → `bus_req_valid` held high and stable, stall high throughout, completes normally.
- Slave never responds, `TIMEOUT_CYCLES` = 8 → DONE after 8 cycles, `core_rdata` = 0xDEAD_BEEF, `bus_err` = 1 and still set after the next good read.
- Reset asserted while in WAIT → `bus_req_valid` = 0 and state IDLE at the next edge, late `bus_rsp_valid` ignored.
- With `DMEM_LAST_READ_BUF_EN`: two reads of 0x40 → the second shows no `bus_req_valid` and 1 stall cycle; after a write of 7 to 0x40, a read of 0x40 returns 7.
